// File: rtl/l2_ctrl_regs_gen.sv
// rtl/l2_ctrl_regs_gen.sv - L2 controller state-register bank
// Purpose: state registers that sit beside the L2 FSM. It holds the flush
//   set/way walker, the request credit counter, the forward-stall slot tracker
//   and the generic set/clear status flags. Every output is a register or a
//   decode of one, so the FSM sees a change one cycle after the input.
// Optional feature: define LLSC_EN to add the lr_to_xmw/lr_idx stall-resolution
//   path and the ongoing_llsc_conflict flag with its set/clear inputs.
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   flush_start/step/abort        flush walker control
//   flush_busy/done/set/way       flush walker status and current position
//   req_alloc/req_free            consume / return one request credit
//   reqs_cnt/reqs_none            free credits and the zero indication
//   cnt_err/cnt_err_clr           sticky credit/stall overflow error and its clear
//   stall_set/stall_idx           record a forward stall on a request index
//   put_valid/put_idx             request write-back that resolves matching stalls
//   put_atomic/atomic_idx         atomic request completing with the write-back
//   stall_valid/full/ended        slot occupancy, all-full, sticky "some slot resolved"
//   clr_stall_ended               clear stall_ended
//   flag_set/flag_clr/flags       generic status flags, clear wins per bit
module l2_ctrl_regs_gen #(
    parameter int SET_BITS  = 8,
    parameter int WAY_BITS  = 3,
    parameter int N_REQS    = 4,
    parameter int N_STALL   = 2,
    parameter int N_FLAGS   = 3,
    localparam int REQS_BITS = $clog2(N_REQS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_start,
    input  logic                 flush_step,
    input  logic                 flush_abort,
    output logic                 flush_busy,
    output logic                 flush_done,
    output logic [SET_BITS-1:0]  flush_set,
    output logic [WAY_BITS-1:0]  flush_way,
    input  logic                 req_alloc,
    input  logic                 req_free,
    output logic [REQS_BITS:0]   reqs_cnt,
    output logic                 reqs_none,
    output logic                 cnt_err,
    input  logic                 cnt_err_clr,
    input  logic                 stall_set,
    input  logic [REQS_BITS-1:0] stall_idx,
    input  logic                 put_valid,
    input  logic [REQS_BITS-1:0] put_idx,
    input  logic                 put_atomic,
    input  logic [REQS_BITS-1:0] atomic_idx,
    output logic [N_STALL-1:0]   stall_valid,
    output logic                 stall_full,
    output logic                 stall_ended,
    input  logic                 clr_stall_ended,
`ifdef LLSC_EN
    input  logic                 lr_to_xmw,
    input  logic [REQS_BITS-1:0] lr_idx,
    input  logic                 set_llsc_conflict,
    input  logic                 clr_llsc_conflict,
    output logic                 ongoing_llsc_conflict,
`endif
    input  logic [N_FLAGS-1:0]   flag_set,
    input  logic [N_FLAGS-1:0]   flag_clr,
    output logic [N_FLAGS-1:0]   flags
);

    localparam int CW = REQS_BITS + 1;
    localparam logic [REQS_BITS:0] CNT_MAX = CW'(N_REQS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_DRAIN,
        ST_DONE
    } flush_state_e;

    flush_state_e                         state_q, state_d;
    logic [SET_BITS-1:0]                  set_q, set_d;
    logic [WAY_BITS-1:0]                  way_q, way_d;
    logic [REQS_BITS:0]                   cnt_q, cnt_d;
    logic                                 cnt_err_q, cnt_err_d;
    logic [N_STALL-1:0]                   slot_v_q, slot_v_d;
    logic [N_STALL-1:0][REQS_BITS-1:0]    slot_idx_q, slot_idx_d;
    logic                                 ended_q, ended_d;
    logic [N_FLAGS-1:0]                   flags_q, flags_d;
    logic [N_STALL-1:0]                   slot_hit;
    logic                                 slot_found;
    logic                                 stall_drop;
    logic                                 alloc_only, free_only, cnt_bad;
`ifdef LLSC_EN
    logic                                 llsc_q, llsc_d;
`endif

    // Flush walker: ways advance fastest, sets carry; the final step wraps
    // both counters to zero on the way into DRAIN.
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_start) begin
                    state_d = ST_WALK;
                    set_d   = '0;
                    way_d   = '0;
                end
            end
            ST_WALK: begin
                if (flush_abort) begin
                    state_d = ST_IDLE;
                end else if (flush_step) begin
                    way_d = way_q + WAY_BITS'(1);
                    if (&way_q) begin
                        set_d = set_q + SET_BITS'(1);
                        if (&set_q) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Wait until every outstanding request has returned its credit.
                if (flush_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Credits: a simultaneous alloc and free cancel out; an out-of-range
    // single operation is dropped and flagged.
    always_comb begin
        alloc_only = req_alloc & ~req_free;
        free_only  = req_free & ~req_alloc;
        cnt_bad    = (alloc_only & (cnt_q == '0)) | (free_only & (cnt_q == CNT_MAX));
        cnt_d      = cnt_q;
        if (alloc_only && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end else if (free_only && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Stall slots: resolution is evaluated on the current occupancy, and the
    // new entry goes into a slot that was free this cycle, so a stall recorded
    // in the same cycle as a matching write-back survives.
    always_comb begin
        slot_v_d   = slot_v_q;
        slot_idx_d = slot_idx_q;
        slot_hit   = '0;
        slot_found = 1'b0;
        for (int i = 0; i < N_STALL; i++) begin
            slot_hit[i] = slot_v_q[i] & put_valid &
                          ((slot_idx_q[i] == put_idx) |
                           (put_atomic & (slot_idx_q[i] == atomic_idx)));
`ifdef LLSC_EN
            slot_hit[i] = slot_hit[i] |
                          (slot_v_q[i] & lr_to_xmw & (slot_idx_q[i] == lr_idx));
`endif
            if (slot_hit[i]) begin
                slot_v_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < N_STALL; i++) begin
            if (stall_set && !slot_found && !slot_v_q[i]) begin
                slot_v_d[i]   = 1'b1;
                slot_idx_d[i] = stall_idx;
                slot_found    = 1'b1;
            end
        end
        stall_drop = stall_set & ~slot_found;
    end

    always_comb begin
        cnt_err_d = cnt_err_clr ? 1'b0 : (cnt_err_q | cnt_bad | stall_drop);
        ended_d   = clr_stall_ended ? 1'b0 : (ended_q | (|slot_hit));
        flags_d   = (flags_q | flag_set) & ~flag_clr;
`ifdef LLSC_EN
        llsc_d    = clr_llsc_conflict ? 1'b0 : (llsc_q | set_llsc_conflict);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            set_q      <= '0;
            way_q      <= '0;
            cnt_q      <= CNT_MAX;
            cnt_err_q  <= 1'b0;
            slot_v_q   <= '0;
            slot_idx_q <= '0;
            ended_q    <= 1'b0;
            flags_q    <= '0;
`ifdef LLSC_EN
            llsc_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            way_q      <= way_d;
            cnt_q      <= cnt_d;
            cnt_err_q  <= cnt_err_d;
            slot_v_q   <= slot_v_d;
            slot_idx_q <= slot_idx_d;
            ended_q    <= ended_d;
            flags_q    <= flags_d;
`ifdef LLSC_EN
            llsc_q     <= llsc_d;
`endif
        end
    end

    assign flush_busy  = (state_q == ST_WALK) || (state_q == ST_DRAIN);
    assign flush_done  = (state_q == ST_DONE);
    assign flush_set   = set_q;
    assign flush_way   = way_q;
    assign reqs_cnt    = cnt_q;
    assign reqs_none   = (cnt_q == '0);
    assign cnt_err     = cnt_err_q;
    assign stall_valid = slot_v_q;
    assign stall_full  = &slot_v_q;
    assign stall_ended = ended_q;
    assign flags       = flags_q;
`ifdef LLSC_EN
    assign ongoing_llsc_conflict = llsc_q;
`endif

endmodule

// File: tb/tb_l2_ctrl_regs_gen.sv
// tb/tb_l2_ctrl_regs_gen.sv - self-checking bench for l2_ctrl_regs_gen
module tb_l2_ctrl_regs_gen;

    localparam int N_REQS  = 4;
    localparam int N_STALL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_start, flush_step, flush_abort;
    logic       req_alloc, req_free, cnt_err_clr;
    logic       stall_set, put_valid, put_atomic, clr_stall_ended;
    logic [1:0] stall_idx, put_idx, atomic_idx;
    logic [2:0] flag_set, flag_clr;

    logic       flush_busy, flush_done;
    logic [1:0] flush_set;
    logic [0:0] flush_way;
    logic [2:0] reqs_cnt;
    logic       reqs_none, cnt_err, stall_full, stall_ended;
    logic [1:0] stall_valid;
    logic [2:0] flags;

    logic       b_flush_busy, b_flush_done;
    logic [7:0] b_flush_set;
    logic [2:0] b_flush_way;
    logic [2:0] b_reqs_cnt;
    logic       b_reqs_none, b_cnt_err, b_stall_full, b_stall_ended;
    logic [1:0] b_stall_valid;
    logic [2:0] b_flags;

    int n_checks = 0;
    int n_errors = 0;

    int       m_cnt;
    bit       m_err;
    bit       m_v[N_STALL];
    int       m_idx[N_STALL];
    bit       m_ended;
    bit [2:0] m_flags;

    l2_ctrl_regs_gen #(.SET_BITS(2), .WAY_BITS(1), .N_REQS(4), .N_STALL(2), .N_FLAGS(3)) dut (
        .clk(clk), .rst(rst),
        .flush_start(flush_start), .flush_step(flush_step), .flush_abort(flush_abort),
        .flush_busy(flush_busy), .flush_done(flush_done), .flush_set(flush_set), .flush_way(flush_way),
        .req_alloc(req_alloc), .req_free(req_free), .reqs_cnt(reqs_cnt), .reqs_none(reqs_none),
        .cnt_err(cnt_err), .cnt_err_clr(cnt_err_clr),
        .stall_set(stall_set), .stall_idx(stall_idx), .put_valid(put_valid), .put_idx(put_idx),
        .put_atomic(put_atomic), .atomic_idx(atomic_idx), .stall_valid(stall_valid),
        .stall_full(stall_full), .stall_ended(stall_ended), .clr_stall_ended(clr_stall_ended),
        .flag_set(flag_set), .flag_clr(flag_clr), .flags(flags)
    );

    l2_ctrl_regs_gen #(.SET_BITS(8), .WAY_BITS(3), .N_REQS(4), .N_STALL(2), .N_FLAGS(3)) dut_big (
        .clk(clk), .rst(rst),
        .flush_start(flush_start), .flush_step(flush_step), .flush_abort(flush_abort),
        .flush_busy(b_flush_busy), .flush_done(b_flush_done), .flush_set(b_flush_set), .flush_way(b_flush_way),
        .req_alloc(req_alloc), .req_free(req_free), .reqs_cnt(b_reqs_cnt), .reqs_none(b_reqs_none),
        .cnt_err(b_cnt_err), .cnt_err_clr(cnt_err_clr),
        .stall_set(stall_set), .stall_idx(stall_idx), .put_valid(put_valid), .put_idx(put_idx),
        .put_atomic(put_atomic), .atomic_idx(atomic_idx), .stall_valid(b_stall_valid),
        .stall_full(b_stall_full), .stall_ended(b_stall_ended), .clr_stall_ended(clr_stall_ended),
        .flag_set(flag_set), .flag_clr(flag_clr), .flags(b_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush_start = 0; flush_step = 0; flush_abort = 0;
        req_alloc = 0; req_free = 0; cnt_err_clr = 0;
        stall_set = 0; stall_idx = 0; put_valid = 0; put_idx = 0;
        put_atomic = 0; atomic_idx = 0; clr_stall_ended = 0;
        flag_set = 0; flag_clr = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        m_cnt = N_REQS; m_err = 0; m_ended = 0; m_flags = 0;
        for (int i = 0; i < N_STALL; i++) begin m_v[i] = 0; m_idx[i] = 0; end
    endtask

    // Next state of the non-flush registers from the behavioural rules.
    task automatic model_step();
        int  cnt_n;
        int  free_slot;
        bit  bad;
        bit  hit_any;
        bit  nv[N_STALL];
        int  nidx[N_STALL];
        cnt_n = m_cnt; bad = 0; hit_any = 0; free_slot = -1;
        if (req_alloc && !req_free) begin
            if (m_cnt == 0) bad = 1; else cnt_n = m_cnt - 1;
        end
        if (req_free && !req_alloc) begin
            if (m_cnt == N_REQS) bad = 1; else cnt_n = m_cnt + 1;
        end
        for (int i = 0; i < N_STALL; i++) begin
            nv[i] = m_v[i]; nidx[i] = m_idx[i];
            if (m_v[i] && put_valid && (m_idx[i] == int'(put_idx) || (put_atomic && m_idx[i] == int'(atomic_idx)))) begin
                nv[i] = 0; hit_any = 1;
            end
            if (!m_v[i] && free_slot < 0) free_slot = i;
        end
        if (stall_set) begin
            if (free_slot < 0) bad = 1;
            else begin nv[free_slot] = 1; nidx[free_slot] = int'(stall_idx); end
        end
        m_cnt   = cnt_n;
        m_err   = cnt_err_clr ? 1'b0 : (m_err | bad);
        m_ended = clr_stall_ended ? 1'b0 : (m_ended | hit_any);
        m_flags = (m_flags | flag_set) & ~flag_clr;
        for (int i = 0; i < N_STALL; i++) begin m_v[i] = nv[i]; m_idx[i] = nidx[i]; end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", flush_busy); end
        n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b expected 0", flush_done); end
        n_checks++; if (flush_set !== 2'd0 || flush_way !== 1'd0) begin n_errors++; $display("FAIL reset_setway: got %0d/%0d expected 0/0", flush_set, flush_way); end
        n_checks++; if (reqs_cnt !== 3'd4) begin n_errors++; $display("FAIL reset_cnt: got %0d expected 4", reqs_cnt); end
        n_checks++; if (reqs_none !== 1'b0 || cnt_err !== 1'b0) begin n_errors++; $display("FAIL reset_none_err: got %0b/%0b expected 0/0", reqs_none, cnt_err); end
        n_checks++; if (stall_valid !== 2'b00 || stall_full !== 1'b0 || stall_ended !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b/%b/%b expected 00/0/0", stall_valid, stall_full, stall_ended); end
        n_checks++; if (flags !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", flags); end
        n_checks++; if (b_flush_busy !== 1'b0 || b_flush_set !== 8'd0 || b_flush_way !== 3'd0 || b_reqs_cnt !== 3'd4) begin n_errors++; $display("FAIL reset_big: got busy %0b set %0d way %0d cnt %0d expected 0 0 0 4", b_flush_busy, b_flush_set, b_flush_way, b_reqs_cnt); end
    endtask

    task automatic test_flush_walk();
        apply_reset();
        flush_start = 1; tick(); flush_start = 0;
        n_checks++; if (flush_busy !== 1'b1) begin n_errors++; $display("FAIL walk_start_busy: got %0b expected 1", flush_busy); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (flush_set !== 2'(k / 2) || flush_way !== 1'(k % 2)) begin n_errors++; $display("FAIL walk_pos%0d: got %0d/%0d expected %0d/%0d", k, flush_set, flush_way, k / 2, k % 2); end
            n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL walk_done%0d: got %0b expected 0", k, flush_done); end
            flush_step  = 1;
            flush_start = (k == 3);
            tick();
        end
        flush_step = 0; flush_start = 0;
        n_checks++; if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin n_errors++; $display("FAIL walk_drain: got busy %0b done %0b expected 1 0", flush_busy, flush_done); end
        n_checks++; if (flush_set !== 2'd0 || flush_way !== 1'd0) begin n_errors++; $display("FAIL walk_wrap: got %0d/%0d expected 0/0", flush_set, flush_way); end
        tick();
        n_checks++; if (flush_done !== 1'b1 || flush_busy !== 1'b0) begin n_errors++; $display("FAIL walk_done_pulse: got done %0b busy %0b expected 1 0", flush_done, flush_busy); end
        tick();
        n_checks++; if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin n_errors++; $display("FAIL walk_done_end: got done %0b busy %0b expected 0 0", flush_done, flush_busy); end
    endtask

    task automatic test_drain_wait();
        apply_reset();
        req_alloc = 1; tick(); req_alloc = 0;
        n_checks++; if (reqs_cnt !== 3'd3) begin n_errors++; $display("FAIL drain_cnt3: got %0d expected 3", reqs_cnt); end
        flush_start = 1; tick(); flush_start = 0;
        flush_step = 1; repeat (8) tick(); flush_step = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin n_errors++; $display("FAIL drain_hold%0d: got busy %0b done %0b expected 1 0", k, flush_busy, flush_done); end
        end
        req_free = 1; tick(); req_free = 0;
        n_checks++; if (reqs_cnt !== 3'd4 || flush_done !== 1'b0) begin n_errors++; $display("FAIL drain_cnt4: got cnt %0d done %0b expected 4 0", reqs_cnt, flush_done); end
        tick();
        n_checks++; if (flush_done !== 1'b1) begin n_errors++; $display("FAIL drain_done: got %0b expected 1", flush_done); end
        tick();
        n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL drain_done_end: got %0b expected 0", flush_done); end
    endtask

    task automatic test_abort();
        apply_reset();
        flush_start = 1; tick(); flush_start = 0;
        flush_step = 1; repeat (3) tick();
        flush_abort = 1; tick(); flush_abort = 0; flush_step = 0;
        n_checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin n_errors++; $display("FAIL abort_walk: got busy %0b done %0b expected 0 0", flush_busy, flush_done); end
        repeat (2) begin
            tick();
            n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL abort_no_done: got %0b expected 0", flush_done); end
        end
        flush_start = 1; tick(); flush_start = 0;
        n_checks++; if (flush_busy !== 1'b1 || flush_set !== 2'd0 || flush_way !== 1'd0) begin n_errors++; $display("FAIL abort_restart: got busy %0b pos %0d/%0d expected 1 0/0", flush_busy, flush_set, flush_way); end
        flush_abort = 1; tick(); flush_abort = 0;
        req_alloc = 1; tick(); req_alloc = 0;
        flush_start = 1; tick(); flush_start = 0;
        flush_step = 1; repeat (8) tick(); flush_step = 0;
        n_checks++; if (flush_busy !== 1'b1) begin n_errors++; $display("FAIL abort_in_drain: got %0b expected 1", flush_busy); end
        flush_abort = 1; tick(); flush_abort = 0;
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL abort_drain_idle: got %0b expected 0", flush_busy); end
        req_free = 1; tick(); req_free = 0;
        tick();
        n_checks++; if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin n_errors++; $display("FAIL abort_drain_after: got done %0b busy %0b expected 0 0", flush_done, flush_busy); end
    endtask

    task automatic test_credits();
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            req_alloc = 1; tick();
            n_checks++; if (reqs_cnt !== 3'(4 - k) || reqs_none !== (k == 4) || cnt_err !== 1'b0) begin n_errors++; $display("FAIL credit_alloc%0d: got cnt %0d none %0b err %0b expected %0d %0b 0", k, reqs_cnt, reqs_none, cnt_err, 4 - k, k == 4); end
        end
        tick();
        n_checks++; if (reqs_cnt !== 3'd0 || reqs_none !== 1'b1 || cnt_err !== 1'b1) begin n_errors++; $display("FAIL credit_underflow: got cnt %0d none %0b err %0b expected 0 1 1", reqs_cnt, reqs_none, cnt_err); end
        req_free = 1; tick();
        n_checks++; if (reqs_cnt !== 3'd0 || cnt_err !== 1'b1) begin n_errors++; $display("FAIL credit_both_at0: got cnt %0d err %0b expected 0 1", reqs_cnt, cnt_err); end
        req_alloc = 0; tick();
        n_checks++; if (reqs_cnt !== 3'd1 || reqs_none !== 1'b0) begin n_errors++; $display("FAIL credit_free1: got cnt %0d none %0b expected 1 0", reqs_cnt, reqs_none); end
        req_alloc = 1; tick(); req_alloc = 0;
        n_checks++; if (reqs_cnt !== 3'd1) begin n_errors++; $display("FAIL credit_both: got %0d expected 1", reqs_cnt); end
        cnt_err_clr = 1; tick(); cnt_err_clr = 0;
        n_checks++; if (reqs_cnt !== 3'd2 || cnt_err !== 1'b0) begin n_errors++; $display("FAIL credit_clr: got cnt %0d err %0b expected 2 0", reqs_cnt, cnt_err); end
        repeat (2) tick();
        cnt_err_clr = 1; tick(); cnt_err_clr = 0;
        n_checks++; if (reqs_cnt !== 3'd4 || cnt_err !== 1'b0) begin n_errors++; $display("FAIL credit_clr_wins: got cnt %0d err %0b expected 4 0", reqs_cnt, cnt_err); end
        tick(); req_free = 0;
        n_checks++; if (reqs_cnt !== 3'd4 || cnt_err !== 1'b1) begin n_errors++; $display("FAIL credit_overflow: got cnt %0d err %0b expected 4 1", reqs_cnt, cnt_err); end
        tick();
        n_checks++; if (cnt_err !== 1'b1) begin n_errors++; $display("FAIL credit_sticky: got %0b expected 1", cnt_err); end
    endtask

    task automatic test_stall();
        apply_reset();
        stall_set = 1; stall_idx = 2; tick();
        n_checks++; if (stall_valid !== 2'b01) begin n_errors++; $display("FAIL stall_first: got %b expected 01", stall_valid); end
        stall_idx = 3; tick(); stall_set = 0;
        n_checks++; if (stall_valid !== 2'b11 || stall_full !== 1'b1) begin n_errors++; $display("FAIL stall_full: got %b/%b expected 11/1", stall_valid, stall_full); end
        put_valid = 1; put_idx = 3; tick(); put_valid = 0;
        n_checks++; if (stall_valid !== 2'b01 || stall_ended !== 1'b1 || stall_full !== 1'b0) begin n_errors++; $display("FAIL stall_put: got %b ended %b full %b expected 01 1 0", stall_valid, stall_ended, stall_full); end
        stall_set = 1; stall_idx = 1; tick();
        stall_idx = 0; tick(); stall_set = 0;
        n_checks++; if (stall_valid !== 2'b11 || cnt_err !== 1'b1) begin n_errors++; $display("FAIL stall_drop: got %b err %b expected 11 1", stall_valid, cnt_err); end
        put_valid = 1; put_idx = 0; put_atomic = 1; atomic_idx = 2; clr_stall_ended = 1; tick();
        put_valid = 0; put_atomic = 0; clr_stall_ended = 0;
        n_checks++; if (stall_valid !== 2'b10 || stall_ended !== 1'b0) begin n_errors++; $display("FAIL stall_atomic_clr: got %b ended %b expected 10 0", stall_valid, stall_ended); end
        stall_set = 1; stall_idx = 1; put_valid = 1; put_idx = 1; tick();
        stall_set = 0; put_valid = 0;
        n_checks++; if (stall_valid !== 2'b01 || stall_ended !== 1'b1) begin n_errors++; $display("FAIL stall_same_cycle: got %b ended %b expected 01 1", stall_valid, stall_ended); end
        put_atomic = 1; atomic_idx = 1; tick(); put_atomic = 0;
        n_checks++; if (stall_valid !== 2'b01) begin n_errors++; $display("FAIL stall_atomic_novalid: got %b expected 01", stall_valid); end
        put_valid = 1; put_idx = 1; tick(); put_valid = 0;
        n_checks++; if (stall_valid !== 2'b00) begin n_errors++; $display("FAIL stall_empty: got %b expected 00", stall_valid); end
    endtask

    task automatic test_flags();
        apply_reset();
        flag_set = 3'b011; flag_clr = 3'b001; tick();
        n_checks++; if (flags !== 3'b010) begin n_errors++; $display("FAIL flags_clr_wins: got %b expected 010", flags); end
        flag_set = 3'b100; flag_clr = 3'b000; tick();
        n_checks++; if (flags !== 3'b110) begin n_errors++; $display("FAIL flags_set: got %b expected 110", flags); end
        flag_set = 3'b000; tick();
        n_checks++; if (flags !== 3'b110) begin n_errors++; $display("FAIL flags_hold: got %b expected 110", flags); end
        flag_clr = 3'b010; tick(); flag_clr = 3'b000;
        n_checks++; if (flags !== 3'b100) begin n_errors++; $display("FAIL flags_clr: got %b expected 100", flags); end
    endtask

    task automatic test_random();
        logic [1:0] ev;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            req_alloc       = 1'($urandom_range(0, 1));
            req_free        = 1'($urandom_range(0, 1));
            cnt_err_clr     = ($urandom_range(0, 7) == 0);
            stall_set       = ($urandom_range(0, 2) == 0);
            stall_idx       = 2'($urandom);
            put_valid       = ($urandom_range(0, 2) == 0);
            put_idx         = 2'($urandom);
            put_atomic      = 1'($urandom_range(0, 1));
            atomic_idx      = 2'($urandom);
            clr_stall_ended = ($urandom_range(0, 5) == 0);
            flag_set        = 3'($urandom) & 3'($urandom);
            flag_clr        = 3'($urandom) & 3'($urandom);
            model_step();
            tick();
            for (int i = 0; i < N_STALL; i++) ev[i] = m_v[i];
            n_checks++; if (reqs_cnt !== 3'(m_cnt) || reqs_none !== (m_cnt == 0)) begin n_errors++; $display("FAIL rand_cnt@%0d: got %0d/%0b expected %0d/%0b", n, reqs_cnt, reqs_none, m_cnt, m_cnt == 0); end
            n_checks++; if (cnt_err !== m_err) begin n_errors++; $display("FAIL rand_err@%0d: got %0b expected %0b", n, cnt_err, m_err); end
            n_checks++; if (stall_valid !== ev || stall_full !== (&ev)) begin n_errors++; $display("FAIL rand_stall@%0d: got %b/%b expected %b/%b", n, stall_valid, stall_full, ev, &ev); end
            n_checks++; if (stall_ended !== m_ended) begin n_errors++; $display("FAIL rand_ended@%0d: got %0b expected %0b", n, stall_ended, m_ended); end
            n_checks++; if (flags !== m_flags) begin n_errors++; $display("FAIL rand_flags@%0d: got %b expected %b", n, flags, m_flags); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_walk();
        apply_reset();
        req_alloc = 1; flag_set = 3'b101; stall_set = 1; stall_idx = 1; tick();
        clear_inputs();
        flush_start = 1; tick(); flush_start = 0;
        flush_step = 1; repeat (40) tick(); flush_step = 0;
        n_checks++; if (b_flush_busy !== 1'b1 || b_flush_set !== 8'd5 || b_flush_way !== 3'd0) begin n_errors++; $display("FAIL mid_walk_pos: got busy %0b set %0d way %0d expected 1 5 0", b_flush_busy, b_flush_set, b_flush_way); end
        #3;
        rst = 0;
        #1;
        n_checks++; if (b_flush_busy !== 1'b0 || b_flush_done !== 1'b0 || b_flush_set !== 8'd0 || b_flush_way !== 3'd0) begin n_errors++; $display("FAIL async_flush: got busy %0b done %0b set %0d way %0d expected 0 0 0 0", b_flush_busy, b_flush_done, b_flush_set, b_flush_way); end
        n_checks++; if (b_reqs_cnt !== 3'd4 || b_reqs_none !== 1'b0 || b_cnt_err !== 1'b0) begin n_errors++; $display("FAIL async_cnt: got %0d/%0b/%0b expected 4/0/0", b_reqs_cnt, b_reqs_none, b_cnt_err); end
        n_checks++; if (b_stall_valid !== 2'b00 || b_stall_full !== 1'b0 || b_stall_ended !== 1'b0 || b_flags !== 3'b000) begin n_errors++; $display("FAIL async_misc: got %b/%b/%b/%b expected 00/0/0/000", b_stall_valid, b_stall_full, b_stall_ended, b_flags); end
        n_checks++; if (reqs_cnt !== 3'd4 || flags !== 3'b000 || stall_valid !== 2'b00) begin n_errors++; $display("FAIL async_small: got cnt %0d flags %b valid %b expected 4 000 00", reqs_cnt, flags, stall_valid); end
        tick();
        rst = 1;
        tick();
        n_checks++; if (b_flush_busy !== 1'b0 || b_flush_set !== 8'd0) begin n_errors++; $display("FAIL after_reset_idle: got busy %0b set %0d expected 0 0", b_flush_busy, b_flush_set); end
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_flush_walk();
        test_drain_wait();
        test_abort();
        test_credits();
        test_stall();
        test_flags();
        test_random();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
